// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Optional subtract mode is enabled by defining SUBTRACT_EN (adds the sub port).
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;
    logic [CHUNK:0]   w_chunk;
    logic             w_accept;

    function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

`ifdef SUBTRACT_EN
    assign w_b_eff = sub ? ~b : b;
    assign w_c_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff = b;
    assign w_c_eff = cin;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    // Operands are shifted right each RUN cycle, so the active chunk is always the low CHUNK bits.
    assign w_chunk  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_idx == LAST_IDX) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shadow fills from the top, so after NCHUNK shifts it holds the full result and no stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_eff;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= w_b_eff[WIDTH-1];
                r_carry <= w_c_eff;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_a      <= r_a >> CHUNK;
                r_b      <= r_b >> CHUNK;
                r_carry  <= w_chunk[CHUNK];
                r_shadow <= (r_shadow >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
                r_idx    <= r_idx + 1'b1;
            end else if (r_state == S_DONE) begin
                r_sum  <= r_shadow;
                r_cout <= r_carry;
                r_ovf  <= f_ovf(r_a_msb, r_b_msb, r_shadow[WIDTH-1]);
                r_done <= 1'b1;
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder (WIDTH=16, CHUNK=4): directed and random operations against an arithmetic model.
module tb_chunked_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_total = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SUBTRACT_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, A - B computed as A + ~B + 1.
    task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] beff;
        logic             ceff;
        beff   = ts ? ~tb_ : tb_;
        ceff   = ts ? 1'b1 : tc;
        full   = {1'b0, ta} + {1'b0, beff} + {{WIDTH{1'b0}}, ceff};
        m_sum  = full[WIDTH-1:0];
        m_cout = full[WIDTH];
        m_ovf  = (ta[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts);
        int lat;
        lat = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_;
        chk({tag, ".busy"}, busy, 1);
        for (int i = 1; i <= 12; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            chk({tag, ".hold"}, sum, m_sum);
            @(negedge clk);
        end
        chk({tag, ".latency"}, lat, NCHUNK + 2);
        model(ta, tb_, tc, ts);
        chk({tag, ".sum"}, sum, m_sum);
        chk({tag, ".cout"}, cout, m_cout);
        chk({tag, ".ovf"}, ovf, m_ovf);
        @(negedge clk);
        chk({tag, ".pulse"}, done, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] va [0:12];
        logic [WIDTH-1:0] vb [0:12];
        int               ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.sum", sum, 0);
        chk("rst.cout", cout, 0);
        chk("rst.ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("cin", 16'h1234, 16'h1111, 1'b1, 1'b0);
        chk("cin.exact", sum, 16'h2346);
        do_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("povf.exact", {sum, cout, ovf}, {16'h8000, 1'b0, 1'b1});
        do_op("novf", 16'h8000, 16'h8000, 1'b0, 1'b0);
        chk("novf.exact", {sum, cout, ovf}, {16'h0000, 1'b1, 1'b1});
`ifdef SUBTRACT_EN
        do_op("sub57", 16'h0005, 16'h0007, 1'b1, 1'b1);
        chk("sub57.exact", {sum, cout, ovf}, {16'hFFFE, 1'b0, 1'b0});
        do_op("sub75", 16'h0007, 16'h0005, 1'b0, 1'b1);
        chk("sub75.exact", {sum, cout}, {16'h0002, 1'b1});
`endif
        for (int r = 0; r < 16; r++) begin
            logic ts;
`ifdef SUBTRACT_EN
            ts = 1'($urandom_range(0, 1));
`else
            ts = 1'b0;
`endif
            do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), ts);
        end

        // start held high with operands changing every cycle: accepts at j=0 and j=6 only
        @(negedge clk);
        cin = 1'b0; sub = 1'b0;
        va[0] = WIDTH'($urandom); vb[0] = WIDTH'($urandom);
        a = va[0]; b = vb[0]; start = 1'b1;
        ndone = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done) ndone++;
            chk("held.done", done, (j == 6 || j == 12));
            if (j == 6 || j == 12) begin
                model(va[j-6], vb[j-6], 1'b0, 1'b0);
                chk("held.sum", sum, m_sum);
                chk("held.cout", cout, m_cout);
            end else begin
                chk("held.hold", sum, m_sum);
            end
            va[j] = WIDTH'($urandom); vb[j] = WIDTH'($urandom);
            a = va[j]; b = vb[j];
            if (j == 12) start = 1'b0;
        end
        chk("held.count", ndone, 2);
        repeat (3) @(negedge clk);
        chk("held.idle", busy, 0);

        // reset during the third RUN cycle
        do_op("pre", 16'h1234, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.sum", sum, 0);
        chk("abort.cout", cout, 0);
        chk("abort.done", done, 0);
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort.nodone", ndone, 0);
        do_op("after", 16'h4321, 16'h1234, 1'b0, 1'b0);
        chk("after.exact", sum, 16'h5555);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
